// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_pkg                                                          |
// | Shared CPU field widths, opcodes and ID/EX bundle types.         |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package cpu_pkg;

    localparam int OPCODE_W   = 6;
    localparam int SHAMT_W    = 5;
    localparam int FUNCT_W    = 6;
    localparam int IMM_W      = 16;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b010011;

    // Everything in a bundle except the two operands, whose width is a
    // parameter of the pipeline register rather than of the ISA.
    typedef struct packed {
        logic [OPCODE_W-1:0]   opcode;
        logic [SHAMT_W-1:0]    shamt;
        logic [FUNCT_W-1:0]    alu_control;
        logic [IMM_W-1:0]      immediate;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic [OPCODE_W-1:0]   opcode;
        logic [XLEN-1:0]       rs_content;
        logic [XLEN-1:0]       rt_content;
        logic [SHAMT_W-1:0]    shamt;
        logic [FUNCT_W-1:0]    alu_control;
        logic [IMM_W-1:0]      immediate;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
    } id_ex_bundle_t;

endpackage
`default_nettype wire

// File: rtl/skid_buffer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | skid_buffer                                                      |
// | Generic 2-entry valid/ready skid buffer with registered in_ready.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module skid_buffer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             r_main_valid;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;

    logic w_xfer_in;
    logic w_xfer_out;
    logic w_main_valid_nxt;
    logic w_skid_valid_nxt;
    logic w_load_main_from_skid;
    logic w_load_main_from_in;
    logic w_load_skid;

    assign w_xfer_in  = in_valid & r_in_ready;
    assign w_xfer_out = r_main_valid & out_ready;

    // The skid is only ever filled while main is held, and in_ready is low
    // whenever the skid is occupied, so main never has two candidates.
    always_comb begin
        w_main_valid_nxt      = r_main_valid;
        w_skid_valid_nxt      = r_skid_valid;
        w_load_main_from_skid = 1'b0;
        w_load_main_from_in   = 1'b0;
        w_load_skid           = 1'b0;
        if (clr) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (!r_main_valid || w_xfer_out) begin
            if (r_skid_valid) begin
                w_load_main_from_skid = 1'b1;
                w_main_valid_nxt      = 1'b1;
                w_skid_valid_nxt      = 1'b0;
            end else if (w_xfer_in) begin
                w_load_main_from_in = 1'b1;
                w_main_valid_nxt    = 1'b1;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_xfer_in) begin
            w_load_skid      = 1'b1;
            w_skid_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
            r_main_data  <= '0;
            r_skid_data  <= '0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= ~w_skid_valid_nxt;
            if (w_load_main_from_skid) begin
                r_main_data <= r_skid_data;
            end else if (w_load_main_from_in) begin
                r_main_data <= in_data;
            end
            if (w_load_skid) begin
                r_skid_data <= in_data;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_main_valid;
    assign out_data  = r_main_data;

endmodule
`default_nettype wire

// File: rtl/id_ex_skid_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | id_ex_skid_reg                                                   |
// | ID/EX pipeline register: skid buffer plus flush and stall count. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module id_ex_skid_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OPCODE_W-1:0]   in_opcode,
    input  logic [DATA_W-1:0]     in_rs_content,
    input  logic [DATA_W-1:0]     in_rt_content,
    input  logic [SHAMT_W-1:0]    in_shamt,
    input  logic [FUNCT_W-1:0]    in_ALU_control,
    input  logic [IMM_W-1:0]      in_immediate,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OPCODE_W-1:0]   out_opcode,
    output logic [DATA_W-1:0]     out_rs_content,
    output logic [DATA_W-1:0]     out_rt_content,
    output logic [SHAMT_W-1:0]    out_shamt,
    output logic [FUNCT_W-1:0]    out_ALU_control,
    output logic [IMM_W-1:0]      out_immediate,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_reg_write,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int BUNDLE_W = 2 * DATA_W + $bits(id_ex_ctrl_t);

    id_ex_ctrl_t          w_in_ctrl;
    id_ex_ctrl_t          w_out_ctrl;
    logic [BUNDLE_W-1:0]  w_in_bundle;
    logic [BUNDLE_W-1:0]  w_out_bundle;
    logic [DATA_W-1:0]    w_out_rs;
    logic [DATA_W-1:0]    w_out_rt;
    logic                 w_out_valid;
    logic [CNT_W-1:0]     r_stall_count;

    always_comb begin
        w_in_ctrl             = '0;
        w_in_ctrl.opcode      = in_opcode;
        w_in_ctrl.shamt       = in_shamt;
        w_in_ctrl.alu_control = in_ALU_control;
        w_in_ctrl.immediate   = in_immediate;
        w_in_ctrl.rd          = in_rd;
        w_in_ctrl.reg_write   = in_reg_write;
    end

    assign w_in_bundle = {in_rs_content, in_rt_content, w_in_ctrl};

    skid_buffer #(
        .WIDTH (BUNDLE_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (w_in_bundle),
        .out_valid (w_out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_bundle)
    );

    assign {w_out_rs, w_out_rt, w_out_ctrl} = w_out_bundle;

    assign out_valid       = w_out_valid;
    assign out_opcode      = w_out_ctrl.opcode;
    assign out_rs_content  = w_out_rs;
    assign out_rt_content  = w_out_rt;
    assign out_shamt       = w_out_ctrl.shamt;
    assign out_ALU_control = w_out_ctrl.alu_control;
    assign out_immediate   = w_out_ctrl.immediate;
    assign out_rd          = w_out_ctrl.rd;
    assign out_reg_write   = w_out_ctrl.reg_write;

    // A flush cycle is not a stall even if the ALU was refusing the bundle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (w_out_valid && !out_ready && !flush && !(&r_stall_count)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_skid_reg.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------+
// | tb_id_ex_skid_reg                                                |
// | Directed and scoreboard checks for the ID/EX skid register.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_id_ex_skid_reg;
    import cpu_pkg::*;

    localparam int DATA_W = 32;
    localparam int BUS_W  = 6 + 2 * DATA_W + 5 + 6 + 16 + 5 + 1;
    localparam int N_RAND = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic flush = 1'b0;
    logic out_ready = 1'b0;
    logic [5:0]        in_opcode = '0;
    logic [DATA_W-1:0] in_rs_content = '0;
    logic [DATA_W-1:0] in_rt_content = '0;
    logic [4:0]        in_shamt = '0;
    logic [5:0]        in_ALU_control = '0;
    logic [15:0]       in_immediate = '0;
    logic [4:0]        in_rd = '0;
    logic              in_reg_write = 1'b0;

    logic              in_ready, out_valid, out_reg_write;
    logic [5:0]        out_opcode, out_ALU_control;
    logic [DATA_W-1:0] out_rs_content, out_rt_content;
    logic [4:0]        out_shamt, out_rd;
    logic [15:0]       out_immediate;
    logic [15:0]       stall_count;

    logic              sat_in_ready, sat_out_valid, sat_out_reg_write;
    logic [5:0]        sat_out_opcode, sat_out_ALU_control;
    logic [DATA_W-1:0] sat_out_rs_content, sat_out_rt_content;
    logic [4:0]        sat_out_shamt, sat_out_rd;
    logic [15:0]       sat_out_immediate;
    logic [3:0]        sat_stall_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [BUS_W-1:0] out_bus;
    assign out_bus = {out_opcode, out_rs_content, out_rt_content, out_shamt,
                      out_ALU_control, out_immediate, out_rd, out_reg_write};

    id_ex_skid_reg #(.DATA_W(DATA_W), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rs_content(in_rs_content), .in_rt_content(in_rt_content),
        .in_shamt(in_shamt), .in_ALU_control(in_ALU_control), .in_immediate(in_immediate),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rs_content(out_rs_content), .out_rt_content(out_rt_content),
        .out_shamt(out_shamt), .out_ALU_control(out_ALU_control), .out_immediate(out_immediate),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .stall_count(stall_count)
    );

    id_ex_skid_reg #(.DATA_W(DATA_W), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_opcode(in_opcode), .in_rs_content(in_rs_content), .in_rt_content(in_rt_content),
        .in_shamt(in_shamt), .in_ALU_control(in_ALU_control), .in_immediate(in_immediate),
        .in_rd(in_rd), .in_reg_write(in_reg_write), .flush(flush),
        .out_valid(sat_out_valid), .out_ready(out_ready),
        .out_opcode(sat_out_opcode), .out_rs_content(sat_out_rs_content),
        .out_rt_content(sat_out_rt_content), .out_shamt(sat_out_shamt),
        .out_ALU_control(sat_out_ALU_control), .out_immediate(sat_out_immediate),
        .out_rd(sat_out_rd), .out_reg_write(sat_out_reg_write), .stall_count(sat_stall_count)
    );

    always #5 clk = ~clk;

    function automatic logic [BUS_W-1:0] mk(input logic [5:0] op, input logic [31:0] rs,
                                            input logic [31:0] rt, input logic [15:0] imm,
                                            input logic [4:0] rd);
        return {op, rs, rt, 5'd0, 6'd0, imm, rd, 1'b1};
    endfunction

    task automatic drive(input logic v, input logic [BUS_W-1:0] b);
        in_valid = v;
        {in_opcode, in_rs_content, in_rt_content, in_shamt,
         in_ALU_control, in_immediate, in_rd, in_reg_write} = b;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #12;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        n_checks++; if (stall_count !== 16'd0) $display("FAIL reset_stall got %0d want 0", stall_count); else n_pass++;
        n_checks++; if (out_bus !== '0) $display("FAIL reset_data got %h want 0", out_bus); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_stream;
        logic [BUS_W-1:0] b [3];
        b[0] = mk(OP_ORI, 32'h9, 32'h0, 16'h9, 5'd1);
        b[1] = mk(OP_ORI, 32'hE, 32'h0, 16'hF, 5'd2);
        b[2] = mk(OP_ORI, 32'h1, 32'h0, 16'h8, 5'd3);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, b[i]);
            n_checks++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready%0d got %b want 1", i, in_ready); else n_pass++;
            tick();
            n_checks++; if (out_valid !== 1'b1) $display("FAIL stream_valid%0d got %b want 1", i, out_valid); else n_pass++;
            n_checks++; if (out_bus !== b[i]) $display("FAIL stream_data%0d got %h want %h", i, out_bus, b[i]); else n_pass++;
        end
        drive(1'b0, '0);
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_drain got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL stream_ready_end got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_backpressure;
        logic [BUS_W-1:0] a, b, c;
        a = mk(OP_RTYPE, 32'hAAAA_0001, 32'h1111_1111, 16'h00A1, 5'd4);
        b = mk(OP_ORI,   32'hBBBB_0002, 32'h2222_2222, 16'h00B2, 5'd5);
        c = mk(OP_BEQ,   32'hCCCC_0003, 32'h3333_3333, 16'h00C3, 5'd6);
        out_ready = 1'b0;
        drive(1'b1, a); tick();
        n_checks++; if (out_bus !== a) $display("FAIL bp_a_held got %h want %h", out_bus, a); else n_pass++;
        drive(1'b1, b); tick();
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready got %b want 0", in_ready); else n_pass++;
        n_checks++; if (stall_count !== 16'd1) $display("FAIL bp_stall1 got %0d want 1", stall_count); else n_pass++;
        drive(1'b1, c); tick();
        n_checks++; if (out_bus !== a) $display("FAIL bp_a_still got %h want %h", out_bus, a); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_c_held_ready got %b want 0", in_ready); else n_pass++;
        out_ready = 1'b1; tick();
        n_checks++; if (out_bus !== b) $display("FAIL bp_b_out got %h want %h", out_bus, b); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_ready_back got %b want 1", in_ready); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_bus !== c) $display("FAIL bp_c_out got %b/%h want 1/%h", out_valid, out_bus, c); else n_pass++;
        drive(1'b0, '0); tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", out_valid); else n_pass++;
        n_checks++; if (stall_count !== 16'd2) $display("FAIL bp_stall_total got %0d want 2", stall_count); else n_pass++;
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        drive(1'b1, mk(OP_ORI, 32'hD, 32'h0, 16'hD, 5'd7)); tick();
        drive(1'b1, mk(OP_ORI, 32'hE, 32'h0, 16'hE, 5'd8)); tick();
        n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_pre_full got %b want 0", in_ready); else n_pass++;
        drive(1'b1, mk(OP_ORI, 32'hF, 32'h0, 16'hF, 5'd9));
        flush = 1'b1; tick(); flush = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_ready got %b want 1", in_ready); else n_pass++;
        n_checks++; if (stall_count !== 16'd3) $display("FAIL flush_stall got %0d want 3", stall_count); else n_pass++;
        drive(1'b0, '0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_no_out%0d got %b want 0", i, out_valid); else n_pass++;
        end
        drive(1'b1, mk(OP_ORI, 32'h77, 32'h0, 16'h77, 5'd10));
        flush = 1'b1; tick(); flush = 1'b0;
        drive(1'b0, '0);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_incoming got %b want 0", out_valid); else n_pass++;
        tick();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_incoming_late got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_async_reset;
        logic [BUS_W-1:0] h;
        h = mk(OP_ORI, 32'h1234_5678, 32'h9ABC_DEF0, 16'h55AA, 5'd11);
        out_ready = 1'b0;
        drive(1'b1, h); tick();
        drive(1'b0, '0); tick();
        n_checks++; if (stall_count !== 16'd4) $display("FAIL areset_pre_stall got %0d want 4", stall_count); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL areset_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (stall_count !== 16'd0) $display("FAIL areset_stall got %0d want 0", stall_count); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL areset_ready got %b want 1", in_ready); else n_pass++;
        n_checks++; if (out_bus !== '0) $display("FAIL areset_data got %h want 0", out_bus); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_saturation;
        logic [BUS_W-1:0] s;
        s = mk(OP_ORI, 32'h5A5A_5A5A, 32'hA5A5_A5A5, 16'h1357, 5'd12);
        out_ready = 1'b0;
        drive(1'b1, s); tick();
        drive(1'b0, '0);
        repeat (20) tick();
        n_checks++; if (sat_stall_count !== 4'd15) $display("FAIL sat_count got %0d want 15", sat_stall_count); else n_pass++;
        n_checks++; if (stall_count !== 16'd20) $display("FAIL sat_wide_count got %0d want 20", stall_count); else n_pass++;
        n_checks++; if (out_bus !== s) $display("FAIL sat_held got %h want %h", out_bus, s); else n_pass++;
        flush = 1'b1; tick(); flush = 1'b0;
        n_checks++; if (sat_stall_count !== 4'd15) $display("FAIL sat_after_flush got %0d want 15", sat_stall_count); else n_pass++;
    endtask

    task automatic test_random;
        logic [BUS_W-1:0] q [$];
        logic [BUS_W-1:0] cur_in, cur_out, exp;
        logic xin, xout;
        int sent, recv, occ, err_order, err_inv, cycles;
        sent = 0; recv = 0; occ = 0; err_order = 0; err_inv = 0; cycles = 0;
        drive(1'b0, '0);
        while (recv < N_RAND && cycles < 20000) begin
            if (!in_valid && sent < N_RAND && $urandom_range(0, 3) != 0) begin
                drive(1'b1, BUS_W'({$urandom(), $urandom(), $urandom(), $urandom()}));
                sent++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (in_ready !== (occ < 2)) err_inv++;
            if (out_valid !== (occ > 0)) err_inv++;
            xin     = in_valid & in_ready;
            xout    = out_valid & out_ready;
            cur_in  = {in_opcode, in_rs_content, in_rt_content, in_shamt,
                       in_ALU_control, in_immediate, in_rd, in_reg_write};
            cur_out = out_bus;
            tick();
            cycles++;
            if (xout) begin
                if (q.size() == 0) begin
                    err_order++;
                end else begin
                    exp = q.pop_front();
                    if (cur_out !== exp) err_order++;
                end
                recv++;
                occ--;
            end
            if (xin) begin
                q.push_back(cur_in);
                occ++;
                in_valid = 1'b0;
            end
        end
        n_checks++; if (recv != N_RAND) $display("FAIL rand_count got %0d want %0d", recv, N_RAND); else n_pass++;
        n_checks++; if (err_order != 0) $display("FAIL rand_order got %0d errors want 0", err_order); else n_pass++;
        n_checks++; if (err_inv != 0) $display("FAIL rand_ready_inv got %0d errors want 0", err_inv); else n_pass++;
        n_checks++; if (q.size() != 0) $display("FAIL rand_leftover got %0d want 0", q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
